instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 125 ++++++++++++
 tb/tb_instr_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Encodes load/store/branch requests into 32-bit instruction words and queues
// them, each paired with its byte address, in a small output FIFO.
module instr_encoder #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    localparam logic [1:0] KIND_LOAD   = 2'b00;
    localparam logic [1:0] KIND_STORE  = 2'b01;
    localparam logic [1:0] KIND_BRANCH = 2'b10;

    logic [31:0]        instr_mem [DEPTH];
    logic [31:0]        addr_mem  [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [OW-1:0]      occ;
    logic [31:0]        addr_cnt;
    logic [31:0]        enc;
    logic [1:0]         chk_code;
    logic signed [31:0] simm;
    logic               accept;
    logic               push;
    logic               pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign simm = in_imm;

    always_comb begin
        enc = '0;
        case (in_kind)
            KIND_LOAD:   enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            KIND_STORE:  enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            KIND_BRANCH: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], 7'b1100011};
            default:     enc = '0;
        endcase
    end

    // Error checks in priority order; 00 means the request is encodable.
    always_comb begin
        chk_code = 2'b00;
        if (in_kind == 2'b11)
            chk_code = 2'b11;
        else if (in_kind == KIND_BRANCH && in_imm[0])
            chk_code = 2'b10;
        else if (in_kind != KIND_BRANCH && (simm < -32'sd2048 || simm > 32'sd2047))
            chk_code = 2'b01;
        else if (in_kind == KIND_BRANCH && (simm < -32'sd4096 || simm > 32'sd4094))
            chk_code = 2'b01;
    end

    assign in_ready  = (occ < FULL);
    assign out_valid = (occ != '0);
    assign accept    = in_valid & in_ready;
    assign push      = accept & (chk_code == 2'b00);
    assign pop       = out_valid & out_ready;

    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign out_addr  = out_valid ? addr_mem[rd_ptr]  : BASE_ADDR;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= enc;
            addr_mem[wr_ptr]  <= addr_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            addr_cnt <= BASE_ADDR;
            err      <= 1'b0;
            err_code <= 2'b00;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= bump(wr_ptr);
                addr_cnt <= addr_cnt + 32'd4;
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
                if (count != 16'hFFFF)
                    count <= count + 16'd1;
            end
            if (push && !pop)
                occ <= occ + 1'b1;
            else if (pop && !push)
                occ <= occ - 1'b1;
            if (accept && chk_code != 2'b00) begin
                err <= 1'b1;
                if (!err)
                    err_code <= chk_code;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed encodings and addresses.
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_code  (err_code),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        in_kind   = k;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        int n = 0;
        set_req(k, rd, rs1, rs2, f3, imm);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("send_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] instr, input logic [31:0] addr);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_instr"}, out_instr, instr);
        chk({tag, "_addr"}, out_addr, addr);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_req(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);

        // reset state
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr",  out_addr,  32'd0);
        chk("rst_err",       {31'b0, err}, 32'd0);
        chk("rst_err_code",  {30'b0, err_code}, 32'd0);
        chk("rst_count",     {16'b0, count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single load, one-cycle latency
        chk("ld_pre_valid", {31'b0, out_valid}, 32'd0);
        send(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, -32'sd4);
        chk("ld_lat_valid", {31'b0, out_valid}, 32'd1);
        expect_pop("ld", 32'hFFC12283, 32'd0);
        chk("ld_count", {16'b0, count}, 32'd1);

        // store then branch
        do_reset();
        send(2'b01, 5'd0, 5'd2, 5'd6, 3'b010, 32'd8);
        send(2'b10, 5'd0, 5'd1, 5'd2, 3'b000, 32'd8);
        expect_pop("st", 32'h00612423, 32'd0);
        expect_pop("br", 32'h00208463, 32'd4);

        // dropped requests, first error code sticks
        do_reset();
        send(2'b10, 5'd0, 5'd1, 5'd2, 3'b000, 32'd3);
        chk("odd_err",      {31'b0, err}, 32'd1);
        chk("odd_code",     {30'b0, err_code}, 32'd2);
        send(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2048);
        chk("rng_code",     {30'b0, err_code}, 32'd2);
        chk("drop_valid",   {31'b0, out_valid}, 32'd0);
        send(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 32'd0);
        expect_pop("after_err", 32'h00000083, 32'd0);
        chk("after_err_err", {31'b0, err}, 32'd1);

        // reserved kind alone
        do_reset();
        send(2'b11, 5'd1, 5'd0, 5'd0, 3'b000, 32'd0);
        chk("rsv_code",  {30'b0, err_code}, 32'd3);
        chk("rsv_valid", {31'b0, out_valid}, 32'd0);

        // immediate boundaries
        do_reset();
        send(2'b00, 5'd0, 5'd0, 5'd0, 3'b000, 32'd2047);
        expect_pop("ld_max", 32'h7FF00003, 32'd0);
        send(2'b01, 5'd0, 5'd0, 5'd0, 3'b000, -32'sd2048);
        expect_pop("st_min", 32'h80000023, 32'd4);
        send(2'b10, 5'd0, 5'd0, 5'd0, 3'b000, -32'sd4096);
        expect_pop("br_min", 32'h80000063, 32'd8);
        send(2'b10, 5'd0, 5'd0, 5'd0, 3'b000, 32'd4094);
        expect_pop("br_max", 32'h7E000FE3, 32'd12);
        chk("bnd_err", {31'b0, err}, 32'd0);
        send(2'b10, 5'd0, 5'd0, 5'd0, 3'b000, 32'd4096);
        chk("br_over_code", {30'b0, err_code}, 32'd1);
        send(2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0);
        chk("code_sticky", {30'b0, err_code}, 32'd1);
        send(2'b01, 5'd0, 5'd0, 5'd0, 3'b000, -32'sd2049);
        chk("st_under_valid", {31'b0, out_valid}, 32'd0);
        send(2'b00, 5'd2, 5'd0, 5'd0, 3'b000, 32'd0);
        expect_pop("addr_kept", 32'h00000103, 32'd16);

        // backpressure with full FIFO
        do_reset();
        send(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 32'd0);
        send(2'b00, 5'd2, 5'd0, 5'd0, 3'b000, 32'd0);
        chk("full_ready", {31'b0, in_ready}, 32'd0);
        set_req(2'b00, 5'd3, 5'd0, 5'd0, 3'b000, 32'd0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_ready", {31'b0, in_ready}, 32'd0);
        chk("hold_addr",  out_addr, 32'd0);
        chk("hold_instr", out_instr, 32'h00000083);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("after_pop_ready", {31'b0, in_ready}, 32'd1);
        chk("after_pop_head",  out_addr, 32'd4);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_pop("drain4", 32'h00000103, 32'd4);
        expect_pop("drain8", 32'h00000183, 32'd8);
        chk("drain_count", {16'b0, count}, 32'd3);
        chk("drain_empty", {31'b0, out_valid}, 32'd0);

        // asynchronous reset with buffered words and err set
        do_reset();
        send(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 32'd0);
        expect_pop("pre_rst", 32'h00000083, 32'd0);
        send(2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0);
        send(2'b00, 5'd2, 5'd0, 5'd0, 3'b000, 32'd0);
        send(2'b00, 5'd3, 5'd0, 5'd0, 3'b000, 32'd0);
        chk("pre_rst_err", {31'b0, err}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_err",   {31'b0, err}, 32'd0);
        chk("arst_count", {16'b0, count}, 32'd0);
        chk("arst_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_addr",  out_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(2'b00, 5'd4, 5'd0, 5'd0, 3'b000, 32'd0);
        expect_pop("post_rst", 32'h00000203, 32'd0);

        // simultaneous push and pop at occupancy 1
        do_reset();
        send(2'b00, 5'd1, 5'd0, 5'd0, 3'b000, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            set_req(2'b00, 5'(i + 1), 5'd0, 5'd0, 3'b000, 32'd0);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            chk("pp_ready", {31'b0, in_ready}, 32'd1);
            chk("pp_valid", {31'b0, out_valid}, 32'd1);
            chk("pp_instr", out_instr, (32'(i) << 7) | 32'd3);
            chk("pp_addr",  out_addr, 32'(i - 1) * 32'd4);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        expect_pop("pp_last", 32'h00000583, 32'd40);
        chk("pp_count", {16'b0, count}, 32'd11);
        chk("pp_empty", {31'b0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
